// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the cache requesters, the memory port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the
// requester/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3
);
    // Request handshake: a requester raises req with stable fields and holds
    // them until its done pulse; req must be dropped in the done cycle.
    // d_wdata_req marks that d_wdata is consumed at the coming edge, after
    // which the next beat must be presented.
    logic                        i_req;
    logic [ADDR_WIDTH-1:0]       i_addr;
    logic                        i_data_valid;
    logic                        i_done;
    logic                        d_req;
    logic                        d_write;
    logic [ADDR_WIDTH-1:0]       d_addr;
    logic [ENTRY_INDEX_SIZE:0]   d_len;
    logic [LEN-1:0]              d_wdata;
    logic                        d_wdata_req;
    logic                        d_rdata_valid;
    logic                        d_done;
    logic [LEN-1:0]              rdata;
    logic [1:0]                  i_cache_mem_vis_signal;
    logic [1:0]                  d_cache_mem_vis_signal;
    logic [ADDR_WIDTH-1:0]       i_cache_mem_vis_addr;
    logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr;
    logic [ENTRY_INDEX_SIZE:0]   length;
    logic [LEN-1:0]              written_data;
    logic [LEN-1:0]              mem_data;

    modport slave (
        input  i_req, i_addr, d_req, d_write, d_addr, d_len, d_wdata, mem_data,
        output i_data_valid, i_done, d_wdata_req, d_rdata_valid, d_done, rdata,
               i_cache_mem_vis_signal, d_cache_mem_vis_signal,
               i_cache_mem_vis_addr, d_cache_mem_vis_addr, length, written_data
    );

    modport master (
        output i_req, i_addr, d_req, d_write, d_addr, d_len, d_wdata, mem_data,
        input  i_data_valid, i_done, d_wdata_req, d_rdata_valid, d_done, rdata,
               i_cache_mem_vis_signal, d_cache_mem_vis_signal,
               i_cache_mem_vis_addr, d_cache_mem_vis_addr, length, written_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the icache (single-word reads) and the
// dcache (burst reads / multi-beat writes). One transaction at a time:
// IDLE -> I_BUSY|D_BUSY -> DRAIN -> IDLE. Memory-side outputs decode from
// registered state only.
// Vis encoding: 0 = MEM_NOP, 1 = MEM_READ, 2 = MEM_WRITE, 3 = MEM_READ_BURST.
// Optional macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// dcache grants with icache waiting, the next contested grant goes to icache.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3
`ifdef MEM_ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT   = 4
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          state_dbg
);
    localparam logic [1:0] MEM_NOP        = 2'd0;
    localparam logic [1:0] MEM_READ       = 2'd1;
    localparam logic [1:0] MEM_WRITE      = 2'd2;
    localparam logic [1:0] MEM_READ_BURST = 2'd3;
    localparam int NW        = ENTRY_INDEX_SIZE + 1;
    localparam int MAX_BEATS = 1 << ENTRY_INDEX_SIZE;

    typedef enum logic [1:0] {IDLE = 2'd0, I_BUSY = 2'd1, D_BUSY = 2'd2, DRAIN = 2'd3} state_t;

    state_t                      state, state_nxt;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [NW-1:0]               len_q;
    logic [ENTRY_INDEX_SIZE-1:0] beat_q;
    logic                        write_q;
    logic                        owner_d_q;
    logic                        rd_valid_q;
    logic [NW-1:0]               len_clamped;
    logic                        grant_d, grant_i, force_i, last_beat;
    logic [LEN-1:0]              rdata_w, wdata_w;

    assign state_dbg = state;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_i = bus.i_req && bus.d_req && (starve_cnt == CW'(STARVE_LIMIT));

    // Count consecutive dcache grants taken while icache is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_i || !bus.i_req) begin
                starve_cnt <= '0;
            end else if (grant_d) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end
`else
    assign force_i = 1'b0;
`endif

    assign grant_d   = bus.d_req && !force_i;
    assign grant_i   = bus.i_req && !grant_d;
    assign last_beat = ({1'b0, beat_q} == (len_q - NW'(1)));

    // Clamp the requested beat count into 1..MAX_BEATS.
    always_comb begin
        len_clamped = bus.d_len;
        if (bus.d_len == '0) begin
            len_clamped = NW'(1);
        end else if (bus.d_len > NW'(MAX_BEATS)) begin
            len_clamped = NW'(MAX_BEATS);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = D_BUSY;
                end else if (grant_i) begin
                    state_nxt = I_BUSY;
                end
            end
            I_BUSY:  state_nxt = DRAIN;
            D_BUSY:  if (last_beat) state_nxt = DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the granted request and step the beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            write_q    <= 1'b0;
            owner_d_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            // Memory returns read data one cycle after each burst beat.
            rd_valid_q <= (state == D_BUSY) && !write_q;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        addr_q    <= bus.d_addr;
                        len_q     <= len_clamped;
                        write_q   <= bus.d_write;
                        owner_d_q <= 1'b1;
                        beat_q    <= '0;
                    end else if (grant_i) begin
                        addr_q    <= bus.i_addr;
                        write_q   <= 1'b0;
                        owner_d_q <= 1'b0;
                        beat_q    <= '0;
                    end
                end
                D_BUSY: begin
                    if (!last_beat) begin
                        beat_q <= beat_q + ENTRY_INDEX_SIZE'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side and requester-side outputs from registered state.
    always_comb begin
        bus.i_cache_mem_vis_signal = MEM_NOP;
        bus.d_cache_mem_vis_signal = MEM_NOP;
        bus.d_wdata_req            = 1'b0;
        bus.i_data_valid           = 1'b0;
        bus.i_done                 = 1'b0;
        bus.d_done                 = 1'b0;
        case (state)
            I_BUSY: bus.i_cache_mem_vis_signal = MEM_READ;
            D_BUSY: begin
                bus.d_cache_mem_vis_signal = write_q ? MEM_WRITE : MEM_READ_BURST;
                bus.d_wdata_req            = write_q;
            end
            DRAIN: begin
                bus.i_data_valid = !owner_d_q;
                bus.i_done       = !owner_d_q;
                bus.d_done       = owner_d_q;
            end
            default: ;
        endcase
    end

    // Address and data paths; beat address wraps modulo the address space.
    assign bus.i_cache_mem_vis_addr = addr_q;
    assign bus.d_cache_mem_vis_addr = addr_q + ADDR_WIDTH'({beat_q, 2'b00});
    assign bus.length               = len_q;
    assign bus.d_rdata_valid        = rd_valid_q;
    assign rdata_w                  = bus.mem_data;
    assign wdata_w                  = bus.d_wdata;
    assign bus.rdata                = rdata_w;
    assign bus.written_data         = wdata_w;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven transactions, a
// read-data scoreboard fed from a shadow memory, and hand-written sequences
// for contention, mid-burst reset and (optionally) starvation guarding.
module tb_mem_port_arbiter;
    localparam logic [1:0] MEM_NOP        = 2'd0;
    localparam logic [1:0] MEM_READ       = 2'd1;
    localparam logic [1:0] MEM_WRITE      = 2'd2;
    localparam logic [1:0] MEM_READ_BURST = 2'd3;
    localparam logic [1:0] ST_IDLE        = 2'd0;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         errors = 0;
    int         checks = 0;

    logic [32:0] exp_q[$];
    logic [31:0] mem    [0:32767];
    logic [31:0] shadow [0:32767];

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int w);
        logic [15:0] lo;
        lo = 16'(w);
        return {lo ^ 16'h5A5A, ~lo};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: writes land at the edge, read data appears next cycle.
    always @(posedge clk) begin
        if (bus.d_cache_mem_vis_signal == MEM_WRITE)
            mem[bus.d_cache_mem_vis_addr[16:2]] = bus.written_data;
        if (bus.i_cache_mem_vis_signal == MEM_READ)
            bus.mem_data <= mem[bus.i_cache_mem_vis_addr[16:2]];
        else if (bus.d_cache_mem_vis_signal == MEM_READ_BURST)
            bus.mem_data <= mem[bus.d_cache_mem_vis_addr[16:2]];
    end

    // Scoreboard: every returned word is popped against the expected queue.
    always @(negedge clk) begin
        if (rst_n && (bus.i_data_valid || bus.d_rdata_valid)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_data: got %0h with no expected entry", bus.rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("sb_rdata", {bus.d_rdata_valid, bus.rdata}, e);
            end
        end
    end

    // Driver: one complete transaction starting at a negedge in IDLE.
    task automatic run_txn(input bit is_d, input bit wr, input logic [16:0] addr,
                           input logic [3:0] len, input int n, input bit fixed);
        logic [31:0] wd [8];
        logic [16:0] ba;
        int          wp;
        int          last;
        bit          wreq_seen;
        for (int b = 0; b < 8; b++)
            wd[b] = fixed ? {8{4'(4'hA + b)}} : $urandom;
        if (!is_d) begin
            exp_q.push_back({1'b0, shadow[addr[16:2]]});
        end else begin
            for (int b = 0; b < n; b++) begin
                ba = addr + 17'(4 * b);
                if (wr) shadow[ba[16:2]] = wd[b];
                else    exp_q.push_back({1'b1, shadow[ba[16:2]]});
            end
        end
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_write = wr; bus.d_addr = addr;
            bus.d_len = len;  bus.d_wdata = wd[0];
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        wp = 0;
        wreq_seen = 1'b0;
        last = is_d ? n + 1 : 2;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (wreq_seen) begin
                wp++;
                bus.d_wdata = (wp < n) ? wd[wp] : '0;
            end
            @(negedge clk);
            wreq_seen = bus.d_wdata_req;
            if (is_d) begin
                ba = addr + 17'(4 * (k - 1));
                check("d_sig", bus.d_cache_mem_vis_signal,
                      (k <= n) ? (wr ? MEM_WRITE : MEM_READ_BURST) : MEM_NOP);
                check("i_sig", bus.i_cache_mem_vis_signal, MEM_NOP);
                check("d_wdata_req", bus.d_wdata_req, wr && k <= n);
                check("d_rdata_valid", bus.d_rdata_valid, !wr && k >= 2);
                check("d_done", bus.d_done, k == last);
                if (k <= n) begin
                    check("d_addr", bus.d_cache_mem_vis_addr, ba);
                    if (wr) check("length", bus.length, n);
                end
            end else begin
                check("i_sig", bus.i_cache_mem_vis_signal, (k == 1) ? MEM_READ : MEM_NOP);
                check("d_sig", bus.d_cache_mem_vis_signal, MEM_NOP);
                check("i_data_valid", bus.i_data_valid, k == 2);
                check("i_done", bus.i_done, k == 2);
                if (k == 1) check("i_addr", bus.i_cache_mem_vis_addr, addr);
            end
            if (k == last) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_gap", state_dbg, ST_IDLE);
        bus.d_wdata = '0;
    endtask

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [16:0] addr;
        logic [3:0]  len;
        int          n;
        bit          fixed;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          first_d, first_i, d_done_c, i_done_c, g_cnt;
        bit          hist [10];
        logic [31:0] w0, w1;

        for (int w = 0; w < 32768; w++) begin
            mem[w]    = pattern(w);
            shadow[w] = pattern(w);
        end
        mem[17'h100 >> 2]    = 32'h11223344;
        shadow[17'h100 >> 2] = 32'h11223344;

        vecs[0] = '{0, 0, 17'h00100, 4'd0,  1, 0};
        vecs[1] = '{1, 1, 17'h00040, 4'd4,  4, 1};
        vecs[2] = '{1, 0, 17'h00040, 4'd4,  4, 0};
        vecs[3] = '{1, 0, 17'h1FFFC, 4'd2,  2, 0};
        vecs[4] = '{1, 1, 17'h00200, 4'd0,  1, 0};
        vecs[5] = '{1, 0, 17'h00200, 4'd0,  1, 0};
        vecs[6] = '{1, 1, 17'h00300, 4'd15, 8, 0};
        vecs[7] = '{1, 0, 17'h00300, 4'd8,  8, 0};
        vecs[8] = '{0, 0, 17'h00304, 4'd0,  1, 0};
        vecs[9] = '{1, 0, 17'h1FFF0, 4'd9,  8, 0};

        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_write = 1'b0;
        bus.d_addr = '0;  bus.d_len = '0;  bus.d_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_i_sig", bus.i_cache_mem_vis_signal, MEM_NOP);
        check("rst_d_sig", bus.d_cache_mem_vis_signal, MEM_NOP);
        check("rst_flags", {bus.i_data_valid, bus.i_done, bus.d_wdata_req,
                            bus.d_rdata_valid, bus.d_done}, 0);
        check("rst_length", bus.length, 0);
        check("rst_d_addr", bus.d_cache_mem_vis_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++)
            run_txn(vecs[v].is_d, vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].n, vecs[v].fixed);

        // Random mix of transactions.
        for (int r = 0; r < 6; r++) begin
            logic [3:0]  rl;
            logic [16:0] ra;
            int          rn;
            rl = 4'($urandom_range(0, 15));
            ra = 17'($urandom_range(0, 17'h1FFFF)) & 17'h1FFFC;
            rn = (rl == 0) ? 1 : ((rl > 8) ? 8 : int'(rl));
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rl, rn, 0);
        end

        // Simultaneous requests: dcache first, icache after one IDLE cycle.
        exp_q.push_back({1'b1, shadow[17'h40 >> 2]});
        exp_q.push_back({1'b1, shadow[17'h44 >> 2]});
        exp_q.push_back({1'b0, shadow[17'h104 >> 2]});
        bus.i_req = 1'b1; bus.i_addr = 17'h104;
        bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 17'h40; bus.d_len = 4'd2;
        first_d = -1; first_i = -1; d_done_c = -1; i_done_c = -1;
        for (int k = 1; k <= 20 && i_done_c < 0; k++) begin
            @(negedge clk);
            if (bus.d_cache_mem_vis_signal != MEM_NOP && first_d < 0) first_d = k;
            if (bus.i_cache_mem_vis_signal == MEM_READ && first_i < 0) first_i = k;
            if (bus.d_done) begin d_done_c = k; bus.d_req = 1'b0; end
            if (bus.i_done) begin i_done_c = k; bus.i_req = 1'b0; end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check("both_first_d", first_d, 1);
        check("both_d_done", d_done_c, 3);
        check("both_first_i", first_i, 5);
        check("both_i_done", i_done_c, 6);
        @(negedge clk);

        // Reset during beat 2 of an 8-beat write.
        w0 = $urandom; w1 = $urandom;
        bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_addr = 17'h500; bus.d_len = 4'd8;
        bus.d_wdata = w0;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1; bus.d_wdata = w1;
        @(negedge clk);
        @(posedge clk); #1; bus.d_wdata = $urandom;
        @(negedge clk);
        check("mid_beat2_addr", bus.d_cache_mem_vis_addr, 17'h508);
        check("mid_beat2_sig", bus.d_cache_mem_vis_signal, MEM_WRITE);
        rst_n = 1'b0;
        bus.d_req = 1'b0;
        #1;
        check("mid_rst_state", state_dbg, ST_IDLE);
        check("mid_rst_d_sig", bus.d_cache_mem_vis_signal, MEM_NOP);
        check("mid_rst_i_sig", bus.i_cache_mem_vis_signal, MEM_NOP);
        check("mid_rst_flags", {bus.i_data_valid, bus.i_done, bus.d_wdata_req,
                                bus.d_rdata_valid, bus.d_done}, 0);
        check("mid_rst_length", bus.length, 0);
        check("mid_rst_d_addr", bus.d_cache_mem_vis_addr, 0);
        shadow[17'h500 >> 2] = w0;
        shadow[17'h504 >> 2] = w1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.d_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_d_sig", bus.d_cache_mem_vis_signal, MEM_NOP);
        end
        run_txn(1, 0, 17'h500, 4'd3, 3, 0);
        run_txn(0, 0, 17'h100, 4'd0, 1, 0);

        // Continuous contention: grant order with and without the guard.
        shadow[17'h7000 >> 2] = 32'h5A5A0000;
        bus.i_req = 1'b1; bus.i_addr = 17'h104;
        bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_addr = 17'h7000; bus.d_len = 4'd1;
        bus.d_wdata = 32'h5A5A0000;
        g_cnt = 0;
        for (int c = 0; c < 300 && g_cnt < 10; c++) begin
            @(negedge clk);
            if (bus.i_cache_mem_vis_signal == MEM_READ)
                exp_q.push_back({1'b0, shadow[17'h104 >> 2]});
            if (bus.d_done) begin
                bus.d_req = 1'b0; hist[g_cnt] = 1'b1; g_cnt++;
            end else if (bus.i_done) begin
                bus.i_req = 1'b0; hist[g_cnt] = 1'b0; g_cnt++;
            end else begin
                bus.i_req = 1'b1; bus.d_req = 1'b1;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_wdata = '0;
        check("starve_grants_seen", g_cnt, 10);
        for (int g = 0; g < g_cnt; g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            check("grant_order", hist[g], (g % 5 == 4) ? 1'b0 : 1'b1);
`else
            check("grant_order", hist[g], 1'b1);
`endif
        end
        repeat (3) @(negedge clk);
        run_txn(1, 0, 17'h7000, 4'd1, 1, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
